// File: rtl/logic_gate_sweeper.sv
// ---------------------------------------------------------------------------
// logic_gate_sweeper
//
// Exhaustive stimulus-and-check engine for a small combinational block.
// A start request sweeps an N-bit vector through every value 0 .. 2^N-1.
// Each value is held for DWELL cycles. On the last cycle of each dwell the
// DUT output is compared against a built-in reference function selected
// by MODE. The engine then reports the mismatch count, the first failing
// vector and a pass flag.
//
// Parameters
//   N      number of DUT inputs (1..8)
//   DWELL  cycles each vector is held (1..255)
//   MODE   reference function: 0 AND, 1 OR, 2 XOR (odd parity), 3 NAND
//
// Ports
//   Clk       in   1    system clock, rising edge
//   Rst_n     in   1    asynchronous active-low reset
//   Start     in   1    sweep request (level or pulse), ignored while busy
//   Vec_s     out  N    stimulus vector to the DUT inputs
//   F_s       in   1    DUT output under test
//   ExpF      out  1    reference value for the current Vec_s
//   Busy      out  1    sweep in progress
//   Done      out  1    sweep finished, results held
//   Pass      out  1    valid with Done, set when no mismatch was seen
//   ErrCnt    out  N+1  mismatch count of the current or last sweep
//   FirstErr  out  N    first mismatching vector (valid when ErrCnt != 0)
// ---------------------------------------------------------------------------
module logic_gate_sweeper #(
    parameter int N     = 2,
    parameter int DWELL = 4,
    parameter int MODE  = 0
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Start,
    output logic [N-1:0] Vec_s,
    input  logic         F_s,
    output logic         ExpF,
    output logic         Busy,
    output logic         Done,
    output logic         Pass,
    output logic [N:0]   ErrCnt,
    output logic [N-1:0] FirstErr
);

    localparam int EW = N + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);
    localparam logic [N-1:0] VEC_LAST   = {N{1'b1}};
    localparam logic [N-1:0] VEC_ONE    = N'(1);
    localparam logic [N:0]   ERR_ONE    = EW'(1);
    localparam logic [N:0]   ERR_ZERO   = {EW{1'b0}};
    localparam logic [N-1:0] VEC_ZERO   = {N{1'b0}};
    localparam logic [1:0]   MODE_SEL   = 2'(MODE);

    // Reference function. XOR of all bits is the odd-parity reduction.
    function automatic logic ref_fn(input logic [N-1:0] v);
        logic r;
        case (MODE_SEL)
            2'd0:    r = &v;
            2'd1:    r = |v;
            2'd2:    r = ^v;
            2'd3:    r = ~(&v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t       state_q, state_d;
    logic [7:0]   d_q, d_d;
    logic [N-1:0] vec_q, vec_d;
    logic [N:0]   err_q, err_d;
    logic [N-1:0] first_q, first_d;
    logic         pass_q, pass_d;
    logic         exp_f_s;
    logic         mismatch_s;

    // Reference value and compare result for the vector currently driven.
    always_comb begin
        exp_f_s    = ref_fn(vec_q);
        mismatch_s = (F_s != exp_f_s);
    end

    // Next-state and result update for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        vec_d   = vec_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_DRIVE;
                    d_d     = 8'd0;
                    vec_d   = VEC_ZERO;
                    err_d   = ERR_ZERO;
                    first_d = VEC_ZERO;
                    pass_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRIVE: begin
                if (d_q < DWELL_LAST) begin
                    d_d = d_q + 8'd1;
                end else begin
                    // Last cycle of this dwell: sample the DUT output.
                    if (mismatch_s) begin
                        err_d = err_q + ERR_ONE;
                        if (err_q == ERR_ZERO) begin
                            first_d = vec_q;
                        end else begin
                            first_d = first_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    // Pass is taken from err_d so the final compare counts.
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        pass_d  = (err_d == ERR_ZERO);
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                        d_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                d_d     = 8'd0;
                vec_d   = VEC_ZERO;
                err_d   = ERR_ZERO;
                first_d = VEC_ZERO;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            d_q     <= 8'd0;
            vec_q   <= VEC_ZERO;
            err_q   <= ERR_ZERO;
            first_q <= VEC_ZERO;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign Vec_s    = vec_q;
    assign ExpF     = exp_f_s;
    assign Busy     = (state_q == ST_DRIVE);
    assign Done     = (state_q == ST_DONE);
    assign Pass     = pass_q;
    assign ErrCnt   = err_q;
    assign FirstErr = first_q;

endmodule
